// File: rtl/mdu_hilo_iter.sv
// ============================================================================
// Module   : mdu_hilo_iter
// Purpose  : Iterative multiply/divide unit with HI/LO registers (EX stage).
//            Define MDU_DIV_EN to build the restoring divider and DIV state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_hilo_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIX = 2'd3} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg_q;

    // Signed ops (MULT/DIV) have op_i[0] clear; iterate on magnitudes.
    logic             sgn_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod_fix;

    assign sgn_op   = ~op_i[0];
    assign a_neg    = sgn_op & a_i[WIDTH-1];
    assign b_neg    = sgn_op & b_i[WIDTH-1];
    assign abs_a    = a_neg ? -a_i : a_i;
    assign abs_b    = b_neg ? -b_i : b_i;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign prod_fix = neg_q ? -acc : acc;

`ifdef MDU_DIV_EN
    logic             neg_r;
    logic             is_div;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, opnd};
    assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
`ifdef MDU_DIV_EN
            neg_r  <= 1'b0;
            is_div <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                acc    <= {{WIDTH{1'b0}}, abs_b};
                                opnd   <= abs_a;
                                neg_q  <= a_neg ^ b_neg;
                                cnt    <= CNT_W'(WIDTH);
                                state  <= MUL;
                                busy_o <= 1'b1;
`ifdef MDU_DIV_EN
                                is_div <= 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                                // Divide by zero keeps the quotient unsigned so it stays all ones.
                                acc    <= {{WIDTH{1'b0}}, abs_a};
                                opnd   <= abs_b;
                                neg_q  <= (a_neg ^ b_neg) & (|b_i);
                                neg_r  <= a_neg;
                                is_div <= 1'b1;
                                cnt    <= CNT_W'(WIDTH);
                                state  <= DIV;
                                busy_o <= 1'b1;
`else
                                done_o <= 1'b1;
`endif
                            end
                            OP_MTHI: hi_o <= a_i;
                            OP_MTLO: lo_o <= a_i;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        if (!diff[WIDTH])
                            acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= FIX;
                    end
                end
`endif
                FIX: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (!flush_i) begin
                        done_o <= 1'b1;
`ifdef MDU_DIV_EN
                        if (is_div) begin
                            hi_o <= rem_fix;
                            lo_o <= quot_fix;
                        end else begin
                            hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_o <= prod_fix[WIDTH-1:0];
                        end
`else
                        hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_o <= prod_fix[WIDTH-1:0];
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo_iter.sv
// ============================================================================
// Module   : tb_mdu_hilo_iter
// Purpose  : Scoreboard bench for mdu_hilo_iter (honours MDU_DIV_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo_iter;

    localparam int W = 32;
    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, NOP = 3'b111;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [2:0]   op_i = NOP;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         flush_i = 1'b0;
    logic         busy_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    mdu_hilo_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [2*W-1:0] cur);
        logic signed [2*W-1:0] sa, sb;
        logic signed [W-1:0]   da, db;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        da = $signed(a);
        db = $signed(b);
        case (op)
            MULT:  return sa * sb;
            MULTU: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            DIV, DIVU: begin
`ifdef MDU_DIV_EN
                if (b == '0) return {a, {W{1'b1}}};
                if (op == DIV && a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}})
                    return {{W{1'b0}}, a};
                if (op == DIV) return {W'(da % db), W'(da / db)};
                return {a % b, a / b};
`else
                return cur;
`endif
            end
            default: return cur;
        endcase
    endfunction

    // Launch at a negedge and observe cycles 1..LAT+4; finishes on a negedge.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int flush_at, input int restart_at,
                          output int done_cyc, output int done_cnt, output int busy_first,
                          output int busy_last, output int busy_cnt, output logic [2*W-1:0] res);
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
        res = {hi_o, lo_o};
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0; op_i = NOP;
        for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
            @(negedge clk);
            flush_i = 1'b0;
            start_i = 1'b0;
            if (busy_o) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
                busy_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    res = {hi_o, lo_o};
                end
            end
            if (cyc == flush_at) flush_i = 1'b1;
            if (cyc == restart_at) begin
                start_i = 1'b1; op_i = MULTU; a_i = 32'h5; b_i = 32'h9;
            end
        end
    endtask

    task automatic move_to(input logic [2:0] op, input logic [W-1:0] d, input logic fl);
        op_i = op; a_i = d; start_i = 1'b1; flush_i = fl;
        @(posedge clk);
        #1 start_i = 1'b0; flush_i = 1'b0; op_i = NOP;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #3 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (hi_o !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi_o); end
        checks++; if (lo_o !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo_o); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int dc, dn, bf, bl, bc;
        logic [2*W-1:0] res, exp;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
        run_op(MULT, 32'hFFFFFFFD, 32'h7, -1, -1, dc, dn, bf, bl, bc, res);
        exp = exp_q.pop_front();
        checks++; if (res !== exp) begin errors++; $display("FAIL mult_result got %h want %h", res, exp); end
        checks++; if (bf !== 1 || bl !== LAT - 1 || bc !== LAT - 1) begin
            errors++; $display("FAIL mult_busy_window got %0d..%0d (%0d) want 1..%0d", bf, bl, bc, LAT - 1); end
        checks++; if (dc !== LAT || dn !== 1) begin
            errors++; $display("FAIL mult_done got cycle %0d count %0d want cycle %0d count 1", dc, dn, LAT); end

        exp_q.push_back(64'hFFFFFFFE_00000001);
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, dc, dn, bf, bl, bc, res);
        exp = exp_q.pop_front();
        checks++; if (res !== exp || dc !== LAT) begin
            errors++; $display("FAIL multu_max got %h at %0d want %h at %0d", res, dc, exp, LAT); end
    endtask

    task automatic test_div;
        int dc, dn, bf, bl, bc;
        logic [2*W-1:0] res, exp;
        logic [2:0]     ops [3] = '{DIV, DIVU, DIV};
        logic [W-1:0]   as  [3] = '{32'hFFFFFFF9, 32'h7, 32'h80000000};
        logic [W-1:0]   bs  [3] = '{32'h2, 32'h0, 32'hFFFFFFFF};
`ifdef MDU_DIV_EN
        logic [2*W-1:0] ex  [3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000007_FFFFFFFF, 64'h00000000_80000000};
        int             lat = LAT;
`else
        logic [2*W-1:0] ex  [3];
        int             lat = 1;
`endif
        for (int i = 0; i < 3; i++) begin
`ifndef MDU_DIV_EN
            ex[i] = {hi_o, lo_o};
`endif
            exp_q.push_back(ex[i]);
            run_op(ops[i], as[i], bs[i], -1, -1, dc, dn, bf, bl, bc, res);
            exp = exp_q.pop_front();
            checks++; if (res !== exp) begin errors++; $display("FAIL div_case%0d got %h want %h", i, res, exp); end
            checks++; if (dc !== lat || dn !== 1 || bc !== lat - 1) begin
                errors++; $display("FAIL div_timing%0d got done %0d/%0d busy %0d want done %0d/1 busy %0d",
                                   i, dc, dn, bc, lat, lat - 1); end
        end
    endtask

    task automatic test_random;
        int dc, dn, bf, bl, bc;
        logic [2*W-1:0] res, exp;
        logic [2:0]     op;
        logic [W-1:0]   a, b;
        int             lat;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i % 4);
            a  = $urandom();
            b  = (i == 6) ? '0 : ($urandom() >> (i * 3));
            lat = LAT;
`ifndef MDU_DIV_EN
            if (op[1]) lat = 1;
`endif
            exp_q.push_back(model(op, a, b, {hi_o, lo_o}));
            run_op(op, a, b, -1, -1, dc, dn, bf, bl, bc, res);
            exp = exp_q.pop_front();
            checks++; if (res !== exp || dc !== lat) begin
                errors++; $display("FAIL random%0d op %0d a %h b %h got %h at %0d want %h at %0d",
                                   i, op, a, b, res, dc, exp, lat); end
        end
    endtask

    task automatic test_mthi_mtlo;
        move_to(MTHI, 32'h12345678, 1'b0);
        checks++; if (hi_o !== 32'h12345678 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL mthi got hi %h busy %b done %b want 12345678 0 0", hi_o, busy_o, done_o); end
        move_to(MTLO, 32'h0000ABCD, 1'b0);
        checks++; if (lo_o !== 32'h0000ABCD) begin errors++; $display("FAIL mtlo got %h want 0000abcd", lo_o); end
        move_to(MTLO, 32'hDEADBEEF, 1'b1);
        checks++; if (lo_o !== 32'h0000ABCD) begin errors++; $display("FAIL mtlo_flush got %h want 0000abcd", lo_o); end
    endtask

    task automatic test_flush;
        int dc, dn, bf, bl, bc;
        logic [2*W-1:0] res;
        int fl_at [2] = '{10, LAT - 1};
        for (int i = 0; i < 2; i++) begin
            move_to(MTHI, 32'h11, 1'b0);
            move_to(MTLO, 32'h22, 1'b0);
`ifdef MDU_DIV_EN
            run_op(DIVU, 32'd100, 32'd3, fl_at[i], -1, dc, dn, bf, bl, bc, res);
`else
            run_op(MULTU, 32'd100, 32'd3, fl_at[i], -1, dc, dn, bf, bl, bc, res);
`endif
            checks++; if (bf !== 1 || bl !== fl_at[i]) begin
                errors++; $display("FAIL flush%0d_busy got %0d..%0d want 1..%0d", i, bf, bl, fl_at[i]); end
            checks++; if (dn !== 0) begin errors++; $display("FAIL flush%0d_done got %0d pulses want 0", i, dn); end
            checks++; if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
                errors++; $display("FAIL flush%0d_hilo got %h/%h want 11/22", i, hi_o, lo_o); end
        end
    endtask

    task automatic test_back_to_back;
        int dc, dn, bf, bl, bc;
        logic [2*W-1:0] res, exp;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFE8);
        run_op(MULT, 32'h6, 32'hFFFFFFFC, -1, 5, dc, dn, bf, bl, bc, res);
        exp = exp_q.pop_front();
        checks++; if (res !== exp || dc !== LAT || dn !== 1) begin
            errors++; $display("FAIL restart_ignored got %h at %0d (%0d pulses) want %h at %0d", res, dc, dn, exp, LAT); end
        exp_q.push_back(model(MULTU, 32'h10001, 32'hFFFF, 64'h0));
        run_op(MULTU, 32'h10001, 32'hFFFF, -1, -1, dc, dn, bf, bl, bc, res);
        exp = exp_q.pop_front();
        checks++; if (res !== exp || dc !== LAT) begin
            errors++; $display("FAIL back_to_back got %h at %0d want %h at %0d", res, dc, exp, LAT); end
    endtask

    task automatic test_reset_mid;
        int dc, dn, bf, bl, bc;
        logic [2*W-1:0] res, exp;
        move_to(MTHI, 32'hAA, 1'b0);
        op_i = MULT; a_i = 32'h1234; b_i = 32'h5678; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0; op_i = NOP;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            errors++; $display("FAIL reset_async got busy %b done %b hi %h lo %h want all 0", busy_o, done_o, hi_o, lo_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(64'h00000000_0000000F);
        run_op(MULTU, 32'd3, 32'd5, -1, -1, dc, dn, bf, bl, bc, res);
        exp = exp_q.pop_front();
        checks++; if (res !== exp || dc !== LAT) begin
            errors++; $display("FAIL after_reset got %h at %0d want %h at %0d", res, dc, exp, LAT); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_mthi_mtlo();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
